guess_game_ctrl: RTL and testbench

- Game controller that consumes the 8-bit pseudo-random stream from the LFSR PRNG (`LFSRprng.prn`).
- Rejection-samples that stream to draw a secret target in 0..MAX_VAL.
- Accepts player guesses from switches/buttons, issues higher/lower/correct hints and counts attempts.
- Drives the value and status fed to the `bcd` / 7-segment display path.

---
 rtl/guess_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: draws a secret target from an LFSR stream by rejection sampling, then scores player guesses.
// Optional best-score tracking is compiled in when BEST_SCORE_EN is defined.
module guess_game_ctrl #(
    parameter int MAX_VAL   = 99,
    parameter int MAX_TRIES = 7,
    parameter int TRY_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       prn,
    output logic             prng_enable,
    input  logic             new_game,
    input  logic             submit,
    input  logic [7:0]       guess,
    output logic             too_high,
    output logic             too_low,
    output logic             win,
    output logic             lose,
    output logic             invalid,
    output logic [TRY_W-1:0] tries,
    output logic [7:0]       disp_val,
    output logic [TRY_W-1:0] best_score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0]       MAX_VAL_B   = 8'(MAX_VAL);
    localparam logic [TRY_W-1:0] MAX_TRIES_T = TRY_W'(MAX_TRIES);

    logic [1:0]       state_q, state_d;
    logic [7:0]       target_q, target_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             too_high_q, too_high_d;
    logic             too_low_q, too_low_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             invalid_q, invalid_d;
    logic [7:0]       disp_val_q, disp_val_d;
    logic             prng_enable_q, prng_enable_d;
    logic             new_game_hist_q, new_game_hist_d;
    logic             submit_hist_q, submit_hist_d;
    logic             new_edge_s;
    logic             sub_edge_s;
    logic [TRY_W-1:0] tries_inc_s;
`ifdef BEST_SCORE_EN
    logic [TRY_W-1:0] best_score_q, best_score_d;
`endif

    // Next-state, flag and display computation
    always_comb begin
        new_game_hist_d = new_game;
        submit_hist_d   = submit;
        new_edge_s      = new_game & ~new_game_hist_q;
        sub_edge_s      = submit & ~submit_hist_q;
        tries_inc_s     = tries_q + TRY_W'(1);
        state_d         = state_q;
        target_d        = target_q;
        tries_d         = tries_q;
        too_high_d      = too_high_q;
        too_low_d       = too_low_q;
        win_d           = win_q;
        lose_d          = lose_q;
        invalid_d       = invalid_q;

        case (state_q)
            S_IDLE: begin
                if (new_edge_s) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                // Out-of-range samples are discarded rather than folded, keeping the draw uniform
                if (prn <= MAX_VAL_B) begin
                    target_d   = prn;
                    tries_d    = {TRY_W{1'b0}};
                    too_high_d = 1'b0;
                    too_low_d  = 1'b0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    invalid_d  = 1'b0;
                    state_d    = S_PLAY;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_PLAY: begin
                if (new_edge_s) begin
                    state_d = S_DRAW;
                end else if (sub_edge_s) begin
                    if (guess > MAX_VAL_B) begin
                        invalid_d  = 1'b1;
                        too_high_d = 1'b0;
                        too_low_d  = 1'b0;
                    end else begin
                        invalid_d = 1'b0;
                        tries_d   = tries_inc_s;
                        if (guess == target_q) begin
                            win_d      = 1'b1;
                            too_high_d = 1'b0;
                            too_low_d  = 1'b0;
                            state_d    = S_DONE;
                        end else if (tries_inc_s == MAX_TRIES_T) begin
                            lose_d     = 1'b1;
                            too_high_d = 1'b0;
                            too_low_d  = 1'b0;
                            state_d    = S_DONE;
                        end else begin
                            too_high_d = (guess > target_q);
                            too_low_d  = (guess < target_q);
                        end
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_DONE: begin
                if (new_edge_s) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        prng_enable_d = (state_d == S_DRAW);
        case (state_d)
            S_PLAY:  disp_val_d = guess;
            S_DONE:  disp_val_d = target_d;
            default: disp_val_d = 8'd0;
        endcase
    end

`ifdef BEST_SCORE_EN
    // Best score only moves on the transition into a won round
    always_comb begin
        best_score_d = best_score_q;
        if ((state_q == S_PLAY) && (state_d == S_DONE) && win_d &&
            ((best_score_q == {TRY_W{1'b0}}) || (tries_d < best_score_q))) begin
            best_score_d = tries_d;
        end else begin
            best_score_d = best_score_q;
        end
    end

    // Best score register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            best_score_q <= {TRY_W{1'b0}};
        end else begin
            best_score_q <= best_score_d;
        end
    end

    assign best_score = best_score_q;
`else
    assign best_score = {TRY_W{1'b0}};
`endif

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            target_q        <= 8'd0;
            tries_q         <= {TRY_W{1'b0}};
            too_high_q      <= 1'b0;
            too_low_q       <= 1'b0;
            win_q           <= 1'b0;
            lose_q          <= 1'b0;
            invalid_q       <= 1'b0;
            disp_val_q      <= 8'd0;
            prng_enable_q   <= 1'b0;
            new_game_hist_q <= 1'b0;
            submit_hist_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            tries_q         <= tries_d;
            too_high_q      <= too_high_d;
            too_low_q       <= too_low_d;
            win_q           <= win_d;
            lose_q          <= lose_d;
            invalid_q       <= invalid_d;
            disp_val_q      <= disp_val_d;
            prng_enable_q   <= prng_enable_d;
            new_game_hist_q <= new_game_hist_d;
            submit_hist_q   <= submit_hist_d;
        end
    end

    assign prng_enable = prng_enable_q;
    assign too_high    = too_high_q;
    assign too_low     = too_low_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign invalid     = invalid_q;
    assign tries       = tries_q;
    assign disp_val    = disp_val_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: directed scenarios plus randomized rounds against a round-level game model.
module tb_guess_game_ctrl;

    localparam int MAX_VAL   = 99;
    localparam int MAX_TRIES = 7;
    localparam int TRY_W     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       prn;
    logic             prng_enable;
    logic             new_game;
    logic             submit;
    logic [7:0]       guess;
    logic             too_high;
    logic             too_low;
    logic             win;
    logic             lose;
    logic             invalid;
    logic [TRY_W-1:0] tries;
    logic [7:0]       disp_val;
    logic [TRY_W-1:0] best_score;

    int checks = 0;
    int errors = 0;

    // Game model state: what a player would know about the round
    int exp_target, exp_tries, exp_best;
    bit exp_hi, exp_lo, exp_win, exp_lose, exp_inv, exp_over;
    int prn_q[$];

    guess_game_ctrl #(.MAX_VAL(MAX_VAL), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
        .clk(clk), .reset(reset), .prn(prn), .prng_enable(prng_enable),
        .new_game(new_game), .submit(submit), .guess(guess),
        .too_high(too_high), .too_low(too_low), .win(win), .lose(lose),
        .invalid(invalid), .tries(tries), .disp_val(disp_val), .best_score(best_score)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_round();
        exp_tries = 0;
        exp_hi = 0; exp_lo = 0; exp_win = 0; exp_lose = 0; exp_inv = 0; exp_over = 0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".prng"}, {31'd0, prng_enable}, 32'd0);
        check_eq({tag, ".flags"}, {27'd0, too_high, too_low, win, lose, invalid}, 32'd0);
        check_eq({tag, ".tries"}, {28'd0, tries}, 32'd0);
        check_eq({tag, ".disp"}, {24'd0, disp_val}, 32'd0);
        check_eq({tag, ".best"}, {28'd0, best_score}, 32'd0);
    endtask

    task automatic check_round(input string tag);
        int exp_disp;
        exp_disp = exp_over ? exp_target : int'(guess);
        check_eq({tag, ".hi"}, {31'd0, too_high}, {31'd0, exp_hi});
        check_eq({tag, ".lo"}, {31'd0, too_low}, {31'd0, exp_lo});
        check_eq({tag, ".win"}, {31'd0, win}, {31'd0, exp_win});
        check_eq({tag, ".lose"}, {31'd0, lose}, {31'd0, exp_lose});
        check_eq({tag, ".inv"}, {31'd0, invalid}, {31'd0, exp_inv});
        check_eq({tag, ".tries"}, {28'd0, tries}, exp_tries);
        check_eq({tag, ".disp"}, {24'd0, disp_val}, exp_disp);
        check_eq({tag, ".best"}, {28'd0, best_score}, exp_best);
    endtask

    task automatic do_reset();
        reset = 1'b1; new_game = 1'b0; submit = 1'b0;
        tick();
        reset = 1'b0;
        exp_best = 0; exp_target = 0;
        model_clear_round();
    endtask

    // Scoring rules of the game, applied per valid button press
    task automatic model_submit(input int g);
        if (!exp_over) begin
            if (g > MAX_VAL) begin
                exp_inv = 1; exp_hi = 0; exp_lo = 0;
            end else begin
                exp_inv = 0;
                exp_tries++;
                exp_hi = 0; exp_lo = 0;
                if (g == exp_target) begin
                    exp_win = 1; exp_over = 1;
`ifdef BEST_SCORE_EN
                    if (exp_best == 0 || exp_tries < exp_best) exp_best = exp_tries;
`endif
                end else if (exp_tries == MAX_TRIES) begin
                    exp_lose = 1; exp_over = 1;
                end else begin
                    exp_hi = (g > exp_target);
                    exp_lo = (g < exp_target);
                end
            end
        end
    endtask

    // Press new_game (optionally with submit) and feed prn_q until a target is accepted
    task automatic start_round(input string tag, input bit with_submit);
        int n, exp_n, prev_tries;
        exp_n = prn_q.size();
        exp_target = prn_q[prn_q.size() - 1];
        prev_tries = exp_tries;
        new_game = 1'b1;
        submit = with_submit;
        tick();
        new_game = 1'b0;
        submit = 1'b0;
        check_eq({tag, ".draw_en"}, {31'd0, prng_enable}, 32'd1);
        if (with_submit) check_eq({tag, ".tries_hold"}, {28'd0, tries}, prev_tries);
        n = 0;
        while (prng_enable === 1'b1 && n < 64) begin
            prn = (prn_q.size() > 0) ? 8'(prn_q.pop_front()) : 8'd5;
            tick();
            n++;
        end
        check_eq({tag, ".draw_cycles"}, n, exp_n);
        model_clear_round();
        check_round({tag, ".play"});
    endtask

    task automatic press(input string tag, input int g);
        guess = 8'(g);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        model_submit(g);
        check_round(tag);
        tick();
    endtask

    initial begin
        prn = 8'd0; guess = 8'd0; new_game = 1'b0; submit = 1'b0; reset = 1'b1;
        tick();
        do_reset();
        check_zero("reset");

        // Immediate accept
        prn_q = '{42};
        start_round("draw42", 1'b0);
        press("g50", 50);
        press("g30", 30);
        press("g42", 42);
        press("done_ignored", 10);

        // Three rejections before accepting 63
        prn_q = '{200, 150, 100, 63};
        start_round("draw63", 1'b0);
        press("g99", 99);
        press("g63", 63);

        // Loss after MAX_TRIES wrong guesses, invalid guess does not count
        prn_q = '{42};
        start_round("lose", 1'b0);
        press("inv120", 120);
        for (int i = 0; i < MAX_TRIES; i++) press($sformatf("wrong%0d", i), i * 3);
        press("after_lose", 42);

        // Held button counts once
        prn_q = '{77};
        start_round("held", 1'b0);
        guess = 8'd10;
        submit = 1'b1;
        repeat (20) tick();
        submit = 1'b0;
        model_submit(10);
        check_round("held");
        tick();

        // Simultaneous new_game and submit: the guess is discarded
        guess = 8'd77;
        prn_q = '{150, 12};
        start_round("abandon", 1'b1);

        // Reset mid-round
        press("pre_reset", 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_best = 0;
        model_clear_round();
        check_zero("mid_reset");

        // Wins in 5, 3 and 6 tries
        for (int r = 0; r < 3; r++) begin
            int need;
            need = (r == 0) ? 5 : (r == 1) ? 3 : 6;
            prn_q = '{255, 10};
            start_round($sformatf("best%0d", r), 1'b0);
            for (int k = 0; k < need - 1; k++) press($sformatf("best%0d_w%0d", r, k), 20 + k);
            press($sformatf("best%0d_win", r), 10);
        end

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            int nrej, t, lo_b, hi_b, g, sel;
            nrej = $urandom_range(0, 3);
            prn_q = {};
            for (int k = 0; k < nrej; k++) prn_q.push_back($urandom_range(MAX_VAL + 1, 255));
            t = $urandom_range(0, MAX_VAL);
            prn_q.push_back(t);
            start_round($sformatf("rnd%0d", r), 1'b0);
            lo_b = 0; hi_b = MAX_VAL;
            for (int k = 0; k < 10 && !exp_over; k++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0) g = $urandom_range(MAX_VAL + 1, 255);
                else if (sel < 5) g = $urandom_range(0, MAX_VAL);
                else g = (lo_b + hi_b) / 2;
                if (g <= MAX_VAL && g > t) hi_b = (g > lo_b) ? g - 1 : lo_b;
                if (g <= MAX_VAL && g < t) lo_b = (g < hi_b) ? g + 1 : hi_b;
                press($sformatf("rnd%0d_%0d", r, k), g);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
